// File: rtl/mmu_pkg.sv
// Shared MMU definitions: walker access types, privilege levels, page-fault
// causes and the walk arbiter state encoding.
package mmu_pkg;

  localparam logic [1:0] ACCESS_FETCH = 2'b00;
  localparam logic [1:0] ACCESS_LOAD  = 2'b01;
  localparam logic [1:0] ACCESS_STORE = 2'b10;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [3:0] FAULT_INST_PAGE  = 4'd12;
  localparam logic [3:0] FAULT_LOAD_PAGE  = 4'd13;
  localparam logic [3:0] FAULT_STORE_PAGE = 4'd15;

  // Requester index used by the arbiter and the owner register
  localparam logic REQ_ITLB = 1'b0;
  localparam logic REQ_DTLB = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_WAIT  = 2'b10,
    ARB_RESP  = 2'b11
  } ptw_arb_state_e;

  // Walker access type for a data-side request
  function automatic logic [1:0] data_access(input logic is_store);
    return is_store ? ACCESS_STORE : ACCESS_LOAD;
  endfunction

endpackage

// File: rtl/ptw_walk_arbiter_rr_arb2.sv
// Two-requester round-robin grant. req_i[0] is the ITLB, req_i[1] the DTLB.
// On a tie the requester opposite to the last winner is granted.
module rr_arb2
  import mmu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  // Grant selection and last-winner update
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == REQ_DTLB) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    if (en_i && gnt_o[1]) begin
      last_d = REQ_DTLB;
    end else if (en_i && gnt_o[0]) begin
      last_d = REQ_ITLB;
    end
  end

  // Last winner resets to DTLB so the first tie goes to the ITLB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_DTLB;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ptw_walk_arbiter.sv
// Shares one Sv32 page table walker between the ITLB and DTLB. Holds one
// pending miss per TLB, grants round-robin, keeps the walker request fields
// stable for the whole walk, routes the result back to the owning TLB and
// drops results invalidated by a flush (sfence.vma / satp write).
//
// state | meaning
// IDLE  | no walk in flight; arbitrate pending slots
// ISSUE | walk_request pulse for one cycle
// WAIT  | walker running; request fields held, wait for walk_done
// RESP  | resp_valid pulse to the owning TLB
module ptw_walk_arbiter
  import mmu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        itlb_miss,
  input  logic [31:0] itlb_vaddr,
  input  logic [1:0]  itlb_priv,
  input  logic        dtlb_miss,
  input  logic [31:0] dtlb_vaddr,
  input  logic        dtlb_store,
  input  logic [1:0]  dtlb_priv,
  input  logic        flush,
  output logic        walk_request,
  output logic [31:0] walk_vaddr,
  output logic [1:0]  walk_access_type,
  output logic [1:0]  walk_priv_mode,
  input  logic        walk_done,
  input  logic        walk_fault,
  input  logic [3:0]  walk_fault_cause,
  input  logic [21:0] walk_ppn,
  input  logic [9:0]  walk_flags,
  input  logic        walk_superpage,
  output logic        itlb_resp_valid,
  output logic        dtlb_resp_valid,
  output logic        resp_fault,
  output logic [3:0]  resp_cause,
  output logic [21:0] resp_ppn,
  output logic [9:0]  resp_flags,
  output logic        resp_superpage,
  output logic        busy
);

  ptw_arb_state_e state_q, state_d;
  logic stale_q, stale_d;
  logic owner_q, owner_d;

  logic        islot_pend_q, islot_pend_d;
  logic [31:0] islot_vaddr_q, islot_vaddr_d;
  logic [1:0]  islot_priv_q, islot_priv_d;
  logic        dslot_pend_q, dslot_pend_d;
  logic [31:0] dslot_vaddr_q, dslot_vaddr_d;
  logic [1:0]  dslot_priv_q, dslot_priv_d;
  logic        dslot_store_q, dslot_store_d;

  logic        walk_request_q, walk_request_d;
  logic [31:0] walk_vaddr_q, walk_vaddr_d;
  logic [1:0]  walk_access_q, walk_access_d;
  logic [1:0]  walk_priv_q, walk_priv_d;
  logic        itlb_resp_q, itlb_resp_d;
  logic        dtlb_resp_q, dtlb_resp_d;
  logic        resp_fault_q, resp_fault_d;
  logic [3:0]  resp_cause_q, resp_cause_d;
  logic [21:0] resp_ppn_q, resp_ppn_d;
  logic [9:0]  resp_flags_q, resp_flags_d;
  logic        resp_super_q, resp_super_d;
  logic        busy_q, busy_d;

  logic [1:0] arb_req;
  logic       arb_en;
  logic [1:0] gnt;
  logic       done_live;

  // A flush in IDLE wipes the slots, so it also suppresses a grant that cycle
  assign arb_en  = (state_q == ARB_IDLE) && !flush;
  assign arb_req = {dslot_pend_q, islot_pend_q} & {2{arb_en}};

  // A result is only delivered if no flush landed during the walk, including
  // one arriving in the same cycle as walk_done
  assign done_live = (state_q == ARB_WAIT) && walk_done && !stale_q && !flush;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .req_i (arb_req),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stale_q <= stale_d;
    end
  end

  // Next-state and stale tracking
  always_comb begin
    state_d = state_q;
    stale_d = stale_q;
    case (state_q)
      ARB_IDLE: begin
        if (|gnt) state_d = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        state_d = ARB_WAIT;
        if (flush) stale_d = 1'b1;
      end
      ARB_WAIT: begin
        if (walk_done) begin
          stale_d = 1'b0;
          state_d = done_live ? ARB_RESP : ARB_IDLE;
        end else if (flush) begin
          stale_d = 1'b1;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
        stale_d = 1'b0;
      end
    endcase
  end

  // Pending slots: a new miss is taken when the slot is free or being flushed
  always_comb begin
    islot_pend_d  = islot_pend_q;
    islot_vaddr_d = islot_vaddr_q;
    islot_priv_d  = islot_priv_q;
    dslot_pend_d  = dslot_pend_q;
    dslot_vaddr_d = dslot_vaddr_q;
    dslot_priv_d  = dslot_priv_q;
    dslot_store_d = dslot_store_q;

    if (itlb_miss && (!islot_pend_q || flush)) begin
      islot_pend_d  = 1'b1;
      islot_vaddr_d = itlb_vaddr;
      islot_priv_d  = itlb_priv;
    end else if (flush || gnt[0]) begin
      islot_pend_d = 1'b0;
    end

    if (dtlb_miss && (!dslot_pend_q || flush)) begin
      dslot_pend_d  = 1'b1;
      dslot_vaddr_d = dtlb_vaddr;
      dslot_priv_d  = dtlb_priv;
      dslot_store_d = dtlb_store;
    end else if (flush || gnt[1]) begin
      dslot_pend_d = 1'b0;
    end
  end

  // Output next values: walk fields load on grant, response bus on live done
  always_comb begin
    owner_d        = owner_q;
    walk_request_d = 1'b0;
    walk_vaddr_d   = walk_vaddr_q;
    walk_access_d  = walk_access_q;
    walk_priv_d    = walk_priv_q;
    itlb_resp_d    = 1'b0;
    dtlb_resp_d    = 1'b0;
    resp_fault_d   = resp_fault_q;
    resp_cause_d   = resp_cause_q;
    resp_ppn_d     = resp_ppn_q;
    resp_flags_d   = resp_flags_q;
    resp_super_d   = resp_super_q;

    if (gnt[0]) begin
      owner_d        = REQ_ITLB;
      walk_request_d = 1'b1;
      walk_vaddr_d   = islot_vaddr_q;
      walk_access_d  = ACCESS_FETCH;
      walk_priv_d    = islot_priv_q;
    end else if (gnt[1]) begin
      owner_d        = REQ_DTLB;
      walk_request_d = 1'b1;
      walk_vaddr_d   = dslot_vaddr_q;
      walk_access_d  = data_access(dslot_store_q);
      walk_priv_d    = dslot_priv_q;
    end

    if (done_live) begin
      itlb_resp_d  = (owner_q == REQ_ITLB);
      dtlb_resp_d  = (owner_q == REQ_DTLB);
      resp_fault_d = walk_fault;
      resp_cause_d = walk_fault_cause;
      resp_ppn_d   = walk_ppn;
      resp_flags_d = walk_flags;
      resp_super_d = walk_superpage;
    end

    busy_d = (state_d != ARB_IDLE) || islot_pend_d || dslot_pend_d;
  end

  // Slot, owner and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q        <= REQ_ITLB;
      islot_pend_q   <= 1'b0;
      islot_vaddr_q  <= '0;
      islot_priv_q   <= '0;
      dslot_pend_q   <= 1'b0;
      dslot_vaddr_q  <= '0;
      dslot_priv_q   <= '0;
      dslot_store_q  <= 1'b0;
      walk_request_q <= 1'b0;
      walk_vaddr_q   <= '0;
      walk_access_q  <= ACCESS_FETCH;
      walk_priv_q    <= PRIV_M;
      itlb_resp_q    <= 1'b0;
      dtlb_resp_q    <= 1'b0;
      resp_fault_q   <= 1'b0;
      resp_cause_q   <= '0;
      resp_ppn_q     <= '0;
      resp_flags_q   <= '0;
      resp_super_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      owner_q        <= owner_d;
      islot_pend_q   <= islot_pend_d;
      islot_vaddr_q  <= islot_vaddr_d;
      islot_priv_q   <= islot_priv_d;
      dslot_pend_q   <= dslot_pend_d;
      dslot_vaddr_q  <= dslot_vaddr_d;
      dslot_priv_q   <= dslot_priv_d;
      dslot_store_q  <= dslot_store_d;
      walk_request_q <= walk_request_d;
      walk_vaddr_q   <= walk_vaddr_d;
      walk_access_q  <= walk_access_d;
      walk_priv_q    <= walk_priv_d;
      itlb_resp_q    <= itlb_resp_d;
      dtlb_resp_q    <= dtlb_resp_d;
      resp_fault_q   <= resp_fault_d;
      resp_cause_q   <= resp_cause_d;
      resp_ppn_q     <= resp_ppn_d;
      resp_flags_q   <= resp_flags_d;
      resp_super_q   <= resp_super_d;
      busy_q         <= busy_d;
    end
  end

  assign walk_request     = walk_request_q;
  assign walk_vaddr       = walk_vaddr_q;
  assign walk_access_type = walk_access_q;
  assign walk_priv_mode   = walk_priv_q;
  assign itlb_resp_valid  = itlb_resp_q;
  assign dtlb_resp_valid  = dtlb_resp_q;
  assign resp_fault       = resp_fault_q;
  assign resp_cause       = resp_cause_q;
  assign resp_ppn         = resp_ppn_q;
  assign resp_flags       = resp_flags_q;
  assign resp_superpage   = resp_super_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_ptw_walk_arbiter.sv
// Directed bench for ptw_walk_arbiter. Inputs change and outputs are sampled
// on the falling edge; each tick() advances exactly one clock cycle.
module tb_ptw_walk_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        itlb_miss;
  logic [31:0] itlb_vaddr;
  logic [1:0]  itlb_priv;
  logic        dtlb_miss;
  logic [31:0] dtlb_vaddr;
  logic        dtlb_store;
  logic [1:0]  dtlb_priv;
  logic        flush;
  logic        walk_request;
  logic [31:0] walk_vaddr;
  logic [1:0]  walk_access_type;
  logic [1:0]  walk_priv_mode;
  logic        walk_done;
  logic        walk_fault;
  logic [3:0]  walk_fault_cause;
  logic [21:0] walk_ppn;
  logic [9:0]  walk_flags;
  logic        walk_superpage;
  logic        itlb_resp_valid;
  logic        dtlb_resp_valid;
  logic        resp_fault;
  logic [3:0]  resp_cause;
  logic [21:0] resp_ppn;
  logic [9:0]  resp_flags;
  logic        resp_superpage;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ptw_walk_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .itlb_miss        (itlb_miss),
    .itlb_vaddr       (itlb_vaddr),
    .itlb_priv        (itlb_priv),
    .dtlb_miss        (dtlb_miss),
    .dtlb_vaddr       (dtlb_vaddr),
    .dtlb_store       (dtlb_store),
    .dtlb_priv        (dtlb_priv),
    .flush            (flush),
    .walk_request     (walk_request),
    .walk_vaddr       (walk_vaddr),
    .walk_access_type (walk_access_type),
    .walk_priv_mode   (walk_priv_mode),
    .walk_done        (walk_done),
    .walk_fault       (walk_fault),
    .walk_fault_cause (walk_fault_cause),
    .walk_ppn         (walk_ppn),
    .walk_flags       (walk_flags),
    .walk_superpage   (walk_superpage),
    .itlb_resp_valid  (itlb_resp_valid),
    .dtlb_resp_valid  (dtlb_resp_valid),
    .resp_fault       (resp_fault),
    .resp_cause       (resp_cause),
    .resp_ppn         (resp_ppn),
    .resp_flags       (resp_flags),
    .resp_superpage   (resp_superpage),
    .busy             (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic set_i(input logic [31:0] va, input logic [1:0] pv);
    itlb_miss  = 1'b1;
    itlb_vaddr = va;
    itlb_priv  = pv;
  endtask

  task automatic set_d(input logic [31:0] va, input logic st, input logic [1:0] pv);
    dtlb_miss  = 1'b1;
    dtlb_vaddr = va;
    dtlb_store = st;
    dtlb_priv  = pv;
  endtask

  task automatic clr_miss();
    itlb_miss = 1'b0;
    dtlb_miss = 1'b0;
    flush     = 1'b0;
  endtask

  // Drive walk_done for one cycle; returns one cycle later, where resp_valid is due
  task automatic done(input logic f, input logic [3:0] c, input logic [21:0] ppn,
                      input logic [9:0] fl, input logic sp);
    walk_done        = 1'b1;
    walk_fault       = f;
    walk_fault_cause = c;
    walk_ppn         = ppn;
    walk_flags       = fl;
    walk_superpage   = sp;
    tick();
    walk_done        = 1'b0;
    walk_fault       = 1'b0;
    walk_fault_cause = 4'd0;
    walk_ppn         = 22'd0;
    walk_flags       = 10'd0;
    walk_superpage   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_miss();
    itlb_vaddr = '0; itlb_priv = '0;
    dtlb_vaddr = '0; dtlb_store = 1'b0; dtlb_priv = '0;
    walk_done = 1'b0; walk_fault = 1'b0; walk_fault_cause = '0;
    walk_ppn = '0; walk_flags = '0; walk_superpage = 1'b0;
    tick(3);

    // Reset values
    check("rst_req",   walk_request, 0);
    check("rst_vaddr", walk_vaddr, 0);
    check("rst_acc",   walk_access_type, 0);
    check("rst_priv",  walk_priv_mode, 2'b11);
    check("rst_busy",  busy, 0);
    check("rst_resp",  {itlb_resp_valid, dtlb_resp_valid, resp_fault}, 0);
    rst = 1'b0;
    tick();

    // Simultaneous pair after reset: ITLB first, then DTLB
    set_i(32'h0000_2000, 2'b00);
    set_d(32'h8000_0040, 1'b0, 2'b01);
    tick(); clr_miss();
    check("p1_busy", busy, 1);
    check("p1_noreq_c1", walk_request, 0);
    tick();
    check("p1_req_i",   walk_request, 1);
    check("p1_vaddr_i", walk_vaddr, 32'h0000_2000);
    check("p1_acc_i",   walk_access_type, 2'b00);
    tick();
    done(1'b0, 4'd0, 22'h00AAA, 10'h0CF, 1'b0);
    check("p1_iresp",  {itlb_resp_valid, dtlb_resp_valid}, 2'b10);
    check("p1_ippn",   resp_ppn, 22'h00AAA);
    check("p1_iflags", resp_flags, 10'h0CF);
    tick();
    check("p1_idle_noreq", walk_request, 0);
    tick();
    check("p1_req_d",   walk_request, 1);
    check("p1_vaddr_d", walk_vaddr, 32'h8000_0040);
    check("p1_acc_d",   walk_access_type, 2'b01);
    check("p1_priv_d",  walk_priv_mode, 2'b01);
    tick();
    done(1'b0, 4'd0, 22'h00BBB, 10'h0C7, 1'b1);
    check("p1_dresp", {itlb_resp_valid, dtlb_resp_valid}, 2'b01);
    check("p1_dppn",  resp_ppn, 22'h00BBB);
    check("p1_dsp",   resp_superpage, 1);
    tick();
    check("p1_busy_end", busy, 0);

    // Single ITLB miss, walker done in cycle 6
    set_i(32'h4000_1000, 2'b01);
    tick(); clr_miss();
    check("t1_busy_c1", busy, 1);
    check("t1_noreq_c1", walk_request, 0);
    tick();
    check("t1_req_c2", walk_request, 1);
    check("t1_vaddr",  walk_vaddr, 32'h4000_1000);
    check("t1_acc",    walk_access_type, 2'b00);
    check("t1_priv",   walk_priv_mode, 2'b01);
    tick();
    check("t1_req_c3", walk_request, 0);
    tick(3);
    check("t1_noresp_c6", itlb_resp_valid, 0);
    done(1'b0, 4'd0, 22'h00123, 10'h0CB, 1'b0);
    check("t1_iresp", itlb_resp_valid, 1);
    check("t1_dresp", dtlb_resp_valid, 0);
    check("t1_ppn",   resp_ppn, 22'h00123);
    check("t1_fault", resp_fault, 0);
    tick();
    check("t1_iresp_once", itlb_resp_valid, 0);

    // Second simultaneous pair, last winner ITLB: DTLB first
    set_i(32'h0000_3000, 2'b00);
    set_d(32'h0000_5000, 1'b1, 2'b11);
    tick(); clr_miss();
    tick();
    check("p2_req_d",   walk_request, 1);
    check("p2_vaddr_d", walk_vaddr, 32'h0000_5000);
    check("p2_acc_d",   walk_access_type, 2'b10);
    check("p2_priv_d",  walk_priv_mode, 2'b11);
    tick();
    done(1'b0, 4'd0, 22'h00C01, 10'h0C7, 1'b0);
    check("p2_dresp", {itlb_resp_valid, dtlb_resp_valid}, 2'b01);
    tick(2);
    check("p2_req_i",   walk_request, 1);
    check("p2_vaddr_i", walk_vaddr, 32'h0000_3000);
    tick();
    done(1'b0, 4'd0, 22'h00C02, 10'h0CB, 1'b0);
    check("p2_iresp", {itlb_resp_valid, dtlb_resp_valid}, 2'b10);
    check("p2_ippn",  resp_ppn, 22'h00C02);
    tick();

    // DTLB store miss that faults; request fields held through WAIT
    set_d(32'h1234_5678, 1'b1, 2'b00);
    tick(); clr_miss();
    tick();
    check("t3_req", walk_request, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_acc_hold",   walk_access_type, 2'b10);
      check("t3_vaddr_hold", walk_vaddr, 32'h1234_5678);
    end
    done(1'b1, 4'd15, 22'h0, 10'h0, 1'b0);
    check("t3_dresp", {itlb_resp_valid, dtlb_resp_valid}, 2'b01);
    check("t3_fault", resp_fault, 1);
    check("t3_cause", resp_cause, 4'd15);
    tick();

    // Flush during WAIT with an ITLB miss pending: both dropped
    set_d(32'h6000_0000, 1'b0, 2'b01);
    tick(); clr_miss();
    tick();
    check("t4_req", walk_request, 1);
    tick();
    set_i(32'h6100_0000, 2'b01);
    tick(); clr_miss();
    flush = 1'b1;
    tick(); clr_miss();
    done(1'b0, 4'd0, 22'h00DDD, 10'h0C7, 1'b0);
    check("t4_no_resp", {itlb_resp_valid, dtlb_resp_valid}, 2'b00);
    check("t4_busy",    busy, 0);
    tick(2);
    check("t4_no_req",   walk_request, 0);
    check("t4_no_resp2", {itlb_resp_valid, dtlb_resp_valid}, 2'b00);
    set_i(32'h7000_0000, 2'b00);
    tick(); clr_miss();
    tick();
    check("t4_new_req",   walk_request, 1);
    check("t4_new_vaddr", walk_vaddr, 32'h7000_0000);
    tick();
    done(1'b0, 4'd0, 22'h00EEE, 10'h0CB, 1'b0);
    check("t4_new_iresp", {itlb_resp_valid, dtlb_resp_valid}, 2'b10);
    check("t4_new_ppn",   resp_ppn, 22'h00EEE);
    tick();

    // Flush coinciding with a DTLB miss in IDLE: request survives
    set_d(32'h9000_0000, 1'b0, 2'b01);
    flush = 1'b1;
    tick(); clr_miss();
    check("t5_busy", busy, 1);
    tick();
    check("t5_req",   walk_request, 1);
    check("t5_vaddr", walk_vaddr, 32'h9000_0000);
    tick();
    done(1'b0, 4'd0, 22'h00F0F, 10'h0C7, 1'b0);
    check("t5_dresp", {itlb_resp_valid, dtlb_resp_valid}, 2'b01);
    tick();

    // Reset while in WAIT: outputs clear at once, no response afterwards
    set_i(32'h5000_0000, 2'b01);
    tick(); clr_miss();
    tick();
    check("t6_req", walk_request, 1);
    tick();
    rst = 1'b1;
    #1;
    check("t6_rst_req",   walk_request, 0);
    check("t6_rst_vaddr", walk_vaddr, 0);
    check("t6_rst_acc",   walk_access_type, 0);
    check("t6_rst_priv",  walk_priv_mode, 2'b11);
    check("t6_rst_busy",  busy, 0);
    tick();
    rst = 1'b0;
    tick();
    done(1'b0, 4'd0, 22'h00ABC, 10'h0CB, 1'b0);
    check("t6_no_resp", {itlb_resp_valid, dtlb_resp_valid}, 2'b00);
    tick();
    check("t6_no_resp2", {itlb_resp_valid, dtlb_resp_valid}, 2'b00);
    check("t6_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ptw_walk_arbiter.md
# ptw_walk_arbiter

Shares the single Sv32 page table walker between the instruction TLB and the data TLB. Each TLB signals a miss with a one-cycle pulse. The block queues at most one miss per TLB, grants the walker round-robin and drives the walker's request inputs stable for the whole walk. It returns the walker's result to the TLB that owns the walk and drops results made stale by an `sfence.vma`/`satp` write. It sits in the MMU between both TLBs and `page_table_walker`.

## Interface
- Parameters: none.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- itlb_miss  in  1  one-cycle ITLB miss pulse
- itlb_vaddr  in  32  fetch virtual address, sampled with itlb_miss
- itlb_priv  in  2  fetch privilege, sampled with itlb_miss
- dtlb_miss  in  1  one-cycle DTLB miss pulse
- dtlb_vaddr  in  32  data virtual address, sampled with dtlb_miss
- dtlb_store  in  1  1=store/AMO, 0=load, sampled with dtlb_miss
- dtlb_priv  in  2  effective data privilege (MPRV applied), sampled with dtlb_miss
- flush  in  1  sfence.vma or satp write; invalidates pending and in-flight walks
- walk_request  out  1  walker start pulse
- walk_vaddr  out  32  to walker vaddr
- walk_access_type  out  2  to walker access_type: 00 fetch, 01 load, 10 store
- walk_priv_mode  out  2  to walker priv_mode
- walk_done, walk_fault  in  1 each  from walker
- walk_fault_cause  in  4  from walker
- walk_ppn  in  22  from walker result_ppn
- walk_flags  in  10  from walker result_flags
- walk_superpage  in  1  from walker result_superpage
- itlb_resp_valid  out  1  one-cycle response pulse to ITLB
- dtlb_resp_valid  out  1  one-cycle response pulse to DTLB
- resp_fault  out  1  shared response bus, valid with either resp_valid
- resp_cause  out  4  shared response bus
- resp_ppn  out  22  shared response bus
- resp_flags  out  10  shared response bus
- resp_superpage  out  1  shared response bus
- busy  out  1  state != IDLE or any pending bit set

## Operation
- Pending slots:
  - pend_i, pend_d: one slot each, with captured vaddr, priv and store bit.
  - A miss pulse sets the slot and captures its fields.
  - A pulse while the slot is already set is ignored, including its fields.
- flush clears both pending bits and sets `stale` if state is ISSUE or WAIT.
  - A miss pulse in the same cycle as flush is captured; the request wins.
- Arbitration (IDLE, at least one pending bit set):
  - Only one pending: grant it.
  - Both pending: grant the requester opposite to `last`.
  - On grant: register the walk_* fields from the slot, clear that pend bit, update `last`, go to ISSUE.
- States:
  - IDLE: arbitrate as above.
  - ISSUE: walk_request=1 for exactly this cycle; go to WAIT.
  - WAIT: hold walk_vaddr/access_type/priv_mode constant, because the walker reads access_type combinationally during its walk. On walk_done:
    - If stale=0: latch the result into resp_*, go to RESP.
    - If stale=1: discard the result, clear stale, go to IDLE. No resp_valid is issued; the TLB re-misses under the new translation.
  - RESP: pulse the owner's resp_valid; go to IDLE.
- walk_done is ignored outside WAIT.
- A flush arriving in RESP does not cancel that response, because the TLB fill is already committed.

## Timing
- Reset values:
  - state=IDLE, pend_i=pend_d=0, last=D (the first tie goes to ITLB), stale=0.
  - All outputs 0, including walk_access_type=00.
  - walk_priv_mode=2'b11.
- All outputs are registered.
- Latency from a miss pulse in cycle 0 with the walker idle:
  - pending visible in cycle 1
  - walk_request in cycle 2
  - resp_valid in the cycle after the cycle in which walk_done is sampled.
- Back-to-back service: the next walk_request comes at the earliest 2 cycles after resp_valid (RESP → IDLE → ISSUE).
- Reset mid-walk: the arbiter returns to IDLE immediately; the walker shares rst, so no done is orphaned.

## Structure
- Shared `mmu_pkg` holds:
  - ACCESS_FETCH/LOAD/STORE
  - PRIV_U/S/M
  - FAULT_INST_PAGE/LOAD_PAGE/STORE_PAGE
  - this block's state encoding (IDLE, ISSUE, WAIT, RESP)
- One sub-module is natural: `rr_arb2`, a two-requester round-robin grant with a `last` register and an update enable.

## Test plan
- ITLB miss at vaddr 0x4000_1000, priv S; walker done at +6 with ppn 0x00123 → walk_access_type=00, walk_request in cycle 2, itlb_resp_valid one cycle with resp_ppn=0x00123, dtlb_resp_valid=0.
- Both misses in the same cycle after reset: ITLB granted first, then DTLB; a second simultaneous pair is granted DTLB-first (alternation).
- DTLB store miss; walker returns fault cause 15 → dtlb_resp_valid with resp_fault=1, resp_cause=15, walk_access_type=10 held constant through WAIT.
- flush during WAIT with pend_i set → pend_i cleared, walk_done swallowed, no resp_valid; a new ITLB miss afterward walks normally.
- flush coinciding with a dtlb_miss pulse in IDLE → the DTLB request survives and is issued.
- rst asserted in WAIT → all outputs 0 and walk_priv_mode=11 in the same cycle; no response is ever issued.
